i2c_cmd_sequencer: RTL

Autonomous master that sequences the Avalon-wrapped I2C master core (OpenCores register map) to perform complete single-byte register reads and writes on an I2C slave.
- Sits between a simple request/response client (config FSM, soft-core bridge) and the I2C core's Avalon slave port.
- Programs the prescaler and enable after reset.
- Per request, issues the TXR/CR write and SR poll sequence; reports the data and ACK/error status.

---
 rtl/i2c_cmd_sequencer.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_cmd_sequencer.sv
// Drives an OpenCores I2C master core over Avalon-MM to run complete
// single-byte register reads and writes on an I2C slave.
//
// state      | meaning
// S_INIT     | programming prescaler and enable
// S_IDLE     | waiting for a client request
// S_TXR      | writing TXR for the current byte
// S_CR       | writing CR for the current byte
// S_POLL     | reading SR until TIP clears or timeout
// S_RXR      | reading the received byte
// S_STO      | writing a STOP after NACK or timeout
// S_STO_POLL | reading SR until the bus is free
module i2c_cmd_sequencer #(
  parameter logic [15:0] PRESCALE     = 16'd99,
  parameter logic [19:0] POLL_TIMEOUT = 20'd1000000
) (
  input  logic       csi_clk,
  input  logic       csi_reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rnw,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_status,
  output logic       init_done,
  output logic [2:0] avm_address,
  output logic [7:0] avm_writedata,
  input  logic [7:0] avm_readdata,
  output logic       avm_read,
  output logic       avm_write,
  input  logic       avm_waitrequest
);

  localparam logic [2:0] A_TXRX = 3'd3;
  localparam logic [2:0] A_CRSR = 3'd4;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_TXR, S_CR, S_POLL, S_RXR, S_STO, S_STO_POLL
  } state_t;

  state_t      state;
  logic [1:0]  init_idx;
  logic [1:0]  step;
  logic        rnw;
  logic [6:0]  dev;
  logic [7:0]  reg_idx;
  logic [7:0]  wdata;
  logic [19:0] poll_cnt;
  logic [1:0]  err;

  logic        access_open;
  logic        done;
  logic        step_ack_chk;
  logic        step_last;
  logic [7:0]  step_txr;
  logic [7:0]  step_cr;
  logic        acc_read;
  logic        acc_write;
  logic [2:0]  acc_addr;
  logic [7:0]  acc_data;

  assign access_open = avm_read | avm_write;
  assign done        = access_open & ~avm_waitrequest;

  // Byte steps 0..2 are common address/register/third byte; step 3 is the read byte.
  always_comb begin
    step_ack_chk = 1'b1;
    step_last    = 1'b0;
    step_txr     = 8'h00;
    step_cr      = 8'h00;
    case (step)
      2'd0: begin step_txr = {dev, 1'b0}; step_cr = 8'h90; end
      2'd1: begin step_txr = reg_idx;     step_cr = 8'h10; end
      2'd2: begin
        if (rnw) begin
          step_txr = {dev, 1'b1};
          step_cr  = 8'h90;
        end else begin
          step_txr  = wdata;
          step_cr   = 8'h50;
          step_last = 1'b1;
        end
      end
      default: begin
        step_ack_chk = 1'b0;
        step_cr      = 8'h68;
        step_last    = 1'b1;
      end
    endcase
  end

  always_comb begin
    acc_read  = 1'b0;
    acc_write = 1'b0;
    acc_addr  = A_CRSR;
    acc_data  = 8'h00;
    case (state)
      S_INIT: begin
        acc_write = 1'b1;
        acc_addr  = {1'b0, init_idx};
        acc_data  = (init_idx == 2'd0) ? PRESCALE[7:0] :
                    (init_idx == 2'd1) ? PRESCALE[15:8] : 8'h80;
      end
      S_TXR:      begin acc_write = 1'b1; acc_addr = A_TXRX; acc_data = step_txr; end
      S_CR:       begin acc_write = 1'b1; acc_data = step_cr; end
      S_STO:      begin acc_write = 1'b1; acc_data = 8'h40; end
      S_POLL,
      S_STO_POLL: acc_read = 1'b1;
      S_RXR:      begin acc_read = 1'b1; acc_addr = A_TXRX; end
      default: ;
    endcase
  end

  always_ff @(posedge csi_clk) begin
    if (csi_reset) begin
      state         <= S_INIT;
      init_idx      <= 2'd0;
      step          <= 2'd0;
      rnw           <= 1'b0;
      dev           <= 7'd0;
      reg_idx       <= 8'd0;
      wdata         <= 8'd0;
      poll_cnt      <= 20'd0;
      err           <= 2'b00;
      req_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= 8'd0;
      rsp_status    <= 2'b00;
      init_done     <= 1'b0;
      avm_address   <= 3'd0;
      avm_writedata <= 8'd0;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (state == S_POLL && poll_cnt != 20'hFFFFF)
        poll_cnt <= poll_cnt + 20'd1;

      // One access at a time: launch when the bus is free, drop strobes on completion.
      if (!access_open) begin
        if (acc_read || acc_write) begin
          avm_read      <= acc_read;
          avm_write     <= acc_write;
          avm_address   <= acc_addr;
          avm_writedata <= acc_data;
        end
      end else if (!avm_waitrequest) begin
        avm_read  <= 1'b0;
        avm_write <= 1'b0;
      end

      case (state)
        S_INIT: if (done) begin
          if (init_idx == 2'd2) begin
            init_done <= 1'b1;
            state     <= S_IDLE;
          end else begin
            init_idx <= init_idx + 2'd1;
          end
        end
        S_IDLE: begin
          if (req_valid && req_ready) begin
            rnw       <= req_rnw;
            dev       <= req_dev;
            reg_idx   <= req_reg;
            wdata     <= req_wdata;
            step      <= 2'd0;
            req_ready <= 1'b0;
            state     <= S_TXR;
          end else begin
            req_ready <= 1'b1;
          end
        end
        S_TXR: if (done) state <= S_CR;
        S_CR: if (done) begin
          poll_cnt <= 20'd0;
          state    <= S_POLL;
        end
        S_POLL: if (done) begin
          if (avm_readdata[1]) begin
            // Count is only observed at read completion, so it may step past the limit.
            if (poll_cnt >= POLL_TIMEOUT) begin
              err   <= 2'b11;
              state <= S_STO;
            end
          end else if (avm_readdata[5]) begin
            rsp_valid  <= 1'b1;
            rsp_status <= 2'b10;
            rsp_rdata  <= 8'd0;
            state      <= S_IDLE;
          end else if (step_ack_chk && avm_readdata[7]) begin
            err   <= 2'b01;
            state <= S_STO;
          end else if (step_last && rnw) begin
            state <= S_RXR;
          end else if (step_last) begin
            rsp_valid  <= 1'b1;
            rsp_status <= 2'b00;
            rsp_rdata  <= 8'd0;
            state      <= S_IDLE;
          end else begin
            step  <= step + 2'd1;
            state <= (step == 2'd2) ? S_CR : S_TXR;
          end
        end
        S_RXR: if (done) begin
          rsp_valid  <= 1'b1;
          rsp_status <= 2'b00;
          rsp_rdata  <= avm_readdata;
          state      <= S_IDLE;
        end
        S_STO: if (done) begin
          if (err == 2'b01) begin
            state <= S_STO_POLL;
          end else begin
            rsp_valid  <= 1'b1;
            rsp_status <= err;
            rsp_rdata  <= 8'd0;
            state      <= S_IDLE;
          end
        end
        S_STO_POLL: if (done && !avm_readdata[6]) begin
          rsp_valid  <= 1'b1;
          rsp_status <= 2'b01;
          rsp_rdata  <= 8'd0;
          state      <= S_IDLE;
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule
